// File: rtl/fib_convert_arbiter.sv
// Round-robin arbiter/sequencer sharing one Fibonacci-to-binary converter between NREQ requesters.
// Optional RUN watchdog enabled by defining FIB_ARB_TIMEOUT_EN.
module fib_convert_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 en_convert,
  output logic [31:0]          input_f,
  input  logic                 convert_done,
  input  logic [31:0]          f_b_out
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 2 || TIMEOUT > 1023) begin : g_param_chk
    $error("fib_convert_arbiter: NREQ or TIMEOUT out of range");
  end

  typedef enum logic [1:0] {StIdle, StRun, StResp, StDrain} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] win_q, win_d;
  logic [PtrW-1:0] pick;
  logic            found;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;
  logic            en_convert_q, en_convert_d;
  logic [31:0]     input_f_q, input_f_d;
  logic            tmo;

`ifdef FIB_ARB_TIMEOUT_EN
  logic [9:0] cnt_q, cnt_d;

  // Counter is zero outside RUN, so it is already clear on RUN entry.
  always_comb begin
    cnt_d = 10'd0;
    if (state_q == StRun) cnt_d = cnt_q + 10'd1;
  end

  assign tmo = (cnt_q == 10'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 10'd0;
    else      cnt_q <= cnt_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // First asserted request at or above ptr_q, wrapping modulo NREQ.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + i) % NREQ;
      if (!found && req[PtrW'(idx)]) begin
        found = 1'b1;
        pick  = PtrW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = rsp_data_q;
    input_f_d   = input_f_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d     = StRun;
          win_d       = pick;
          gnt_d[pick] = 1'b1;
          input_f_d   = req_data[32*pick +: 32];
          ptr_d       = (32'(pick) == NREQ - 1) ? '0 : pick + 1'b1;
        end
      end
      StRun: begin
        // A completion in the same cycle as the watchdog limit takes priority.
        if (convert_done) begin
          state_d              = StResp;
          rsp_valid_d[win_q]   = 1'b1;
          rsp_data_d           = f_b_out;
        end else if (tmo) begin
          state_d              = StResp;
          rsp_valid_d[win_q]   = 1'b1;
          rsp_data_d           = 32'h0;
          rsp_err_d            = 1'b1;
        end
      end
      StResp:  state_d = StDrain;
      StDrain: if (!convert_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d       = (state_d != StIdle);
    en_convert_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      win_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= 32'h0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      en_convert_q <= 1'b0;
      input_f_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      win_q        <= win_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
      en_convert_q <= en_convert_d;
      input_f_q    <= input_f_d;
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign en_convert = en_convert_q;
  assign input_f    = input_f_q;

endmodule

// File: tb/tb_fib_convert_arbiter.sv
// Randomized self-checking bench for fib_convert_arbiter with a behavioural converter model.
// Timeout scenario is checked when FIB_ARB_TIMEOUT_EN is defined.
module tb_fib_convert_arbiter;

  localparam int NREQ = 4;
  localparam int TO   = 16;
  localparam logic [31:0] Mask = 32'hFFFF_0000;
`ifdef FIB_ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [32*NREQ-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [31:0]         rsp_data;
  logic                rsp_err;
  logic                busy;
  logic                en_convert;
  logic [31:0]         input_f;
  logic                convert_done;
  logic [31:0]         f_b_out;

  fib_convert_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .gnt          (gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .en_convert   (en_convert),
    .input_f      (input_f),
    .convert_done (convert_done),
    .f_b_out      (f_b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Converter model: result after 5 enabled cycles, done held until enable drops
  // (plus extra_hold cycles); stuck suppresses completion.
  int cv_cnt;
  int hold_left;
  int extra_hold;
  bit stuck;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      cv_cnt       <= 0;
      hold_left    <= 0;
      convert_done <= 1'b0;
      f_b_out      <= 32'h0;
    end else if (en_convert) begin
      if (!stuck) begin
        if (cv_cnt < 5) cv_cnt <= cv_cnt + 1;
        if (cv_cnt >= 4) begin
          convert_done <= 1'b1;
          f_b_out      <= input_f ^ Mask;
        end
      end
      hold_left <= extra_hold;
    end else begin
      cv_cnt <= 0;
      if (convert_done && hold_left > 0) hold_left <= hold_left - 1;
      else convert_done <= 1'b0;
    end
  end

  int n_checks, n_pass;
  int cyc, n_rsp, run_len, mptr;
  int last_gnt_cyc, last_rsp_cyc, last_done_cyc;
  logic [NREQ-1:0] last_rsp_valid;
  logic [31:0]     last_rsp_data;
  logic            last_rsp_err;
  int keep_mode;  // 0 drop on grant, 1 keep requesting, 2 random
  bit rand_en;
  int exp_w_q[$];
  logic [31:0] exp_d_q[$];
  int glog[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic step();
    logic [NREQ-1:0] eg, ev;
    logic pb, pe, pd, prv, tmo, exp_rsp;
    logic [31:0] wd, d2;
    int prl, w, w2;
    pb = busy; pe = en_convert; pd = convert_done; prv = |rsp_valid; prl = run_len;
    eg = '0; w = -1; wd = '0;
    if (!pb && req != '0) begin
      w = rr_pick(req, mptr);
      eg[w] = 1'b1;
      wd = req_data[32*w +: 32];
    end
    tmo     = TmoEn && pe && !pd && (prl == TO);
    exp_rsp = pe && (pd || tmo);
    @(negedge clk);
    cyc++;
    check_eq("gnt", gnt, eg);
    if (w >= 0) begin
      check_eq("gnt_en", en_convert, 1);
      check_eq("gnt_busy", busy, 1);
      exp_w_q.push_back(w);
      exp_d_q.push_back(wd ^ Mask);
      mptr = (w + 1) % NREQ;
      glog.push_back(w);
      last_gnt_cyc = cyc;
      if (keep_mode == 0 || (keep_mode == 2 && $urandom_range(1) == 0)) req[w] = 1'b0;
      else req_data[32*w +: 32] = $urandom();
    end
    if (exp_rsp || rsp_valid != '0) check_eq("rsp_when", |rsp_valid, exp_rsp);
    if (rsp_valid != '0) begin
      n_rsp++;
      last_rsp_cyc = cyc; last_rsp_valid = rsp_valid;
      last_rsp_data = rsp_data; last_rsp_err = rsp_err;
      if (rand_en) extra_hold = $urandom_range(3);
      if (exp_w_q.size() == 0) begin
        check_eq("rsp_unexp", rsp_valid, 0);
      end else begin
        w2 = exp_w_q.pop_front();
        d2 = exp_d_q.pop_front();
        ev = '0; ev[w2] = 1'b1;
        check_eq("rsp_valid", rsp_valid, ev);
        check_eq("rsp_data", rsp_data, tmo ? 32'h0 : d2);
        check_eq("rsp_err", rsp_err, tmo);
        check_eq("rsp_en", en_convert, 0);
      end
    end
    if (pb && pe && !exp_rsp) check_eq("run_hold", en_convert, 1);
    if (pb && !pe && pd) check_eq("drain_hold", busy, 1);
    if (pb && !pe && !pd && !prv) check_eq("drain_exit", busy, 0);
    if (convert_done) last_done_cyc = cyc;
    run_len = en_convert ? run_len + 1 : 0;
    if (rand_en)
      for (int i = 0; i < NREQ; i++)
        if (!req[i] && $urandom_range(3) == 0) begin
          req[i] = 1'b1;
          req_data[32*i +: 32] = $urandom();
        end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_gnt"}, gnt, 0);
    check_eq({tag, "_rsp_valid"}, rsp_valid, 0);
    check_eq({tag, "_rsp_err"}, rsp_err, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_en"}, en_convert, 0);
    check_eq({tag, "_input_f"}, input_f, 0);
    check_eq({tag, "_rsp_data"}, rsp_data, 0);
  endtask

  // Called just after a negedge; asserts reset asynchronously mid-cycle.
  task automatic reset_dut(input string tag);
    #2 rst = 1'b0;
    req = '0;
    #1 check_zero_outputs(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    mptr = 0; run_len = 0;
    exp_w_q.delete(); exp_d_q.delete(); glog.delete();
  endtask

  task automatic run_until_rsp(input string tag, input int max);
    int n0;
    n0 = n_rsp;
    for (int k = 0; k < max && n_rsp == n0; k++) step();
    check_eq(tag, n_rsp - n0, 1);
  endtask

  task automatic run_until_grants(input string tag, input int target, input int max);
    for (int k = 0; k < max && glog.size() < target; k++) step();
    check_eq(tag, glog.size(), target);
  endtask

  task automatic run_until_idle(input string tag, input int max);
    for (int k = 0; k < max && (busy || req != '0 || exp_w_q.size() != 0); k++) step();
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_pending"}, exp_w_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b0; req = '0; req_data = '0;
    stuck = 1'b0; extra_hold = 0; keep_mode = 0; rand_en = 1'b0;
    n_checks = 0; n_pass = 0; cyc = 0; n_rsp = 0; run_len = 0; mptr = 0;
    last_gnt_cyc = 0; last_rsp_cyc = 0; last_done_cyc = 0;
    @(negedge clk);
    check_zero_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Single request
    req = 4'b0010; req_data[63:32] = 32'h0000_0013;
    step();
    check_eq("t1_gnt", gnt, 4'b0010);
    run_until_rsp("t1_rsp_seen", 20);
    check_eq("t1_rsp_valid", last_rsp_valid, 4'b0010);
    check_eq("t1_rsp_data", last_rsp_data, 32'hFFFF_0013);
    check_eq("t1_rsp_err", last_rsp_err, 0);
    run_until_idle("t1_idle", 20);

    // Simultaneous requests after reset
    reset_dut("t2_rst");
    req = 4'b1001; req_data[31:0] = $urandom(); req_data[127:96] = $urandom();
    run_until_grants("t2_grants", 2, 40);
    run_until_idle("t2_idle", 40);
    check_eq("t2_first", glog[0], 0);
    check_eq("t2_second", glog[1], 3);

    // Fairness with all requesters held
    glog.delete();
    keep_mode = 1;
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = $urandom();
    run_until_grants("t3_grants", 8, 200);
    for (int k = 0; k < 8; k++) check_eq("t3_order", glog[k], k % NREQ);
    keep_mode = 0;
    run_until_idle("t3_idle", 200);

    // Done held high after the response
    glog.delete();
    extra_hold = 6;
    req = 4'b1111;
    run_until_grants("t6_grants", 2, 60);
    check_eq("t6_gap", last_gnt_cyc - last_done_cyc, 3);
    run_until_idle("t6_idle", 200);
    extra_hold = 0;

    // Converter never completes
    stuck = 1'b1;
    req = 4'b0001;
    step();
    check_eq("t4_gnt", gnt, 4'b0001);
    n0 = last_gnt_cyc;
`ifdef FIB_ARB_TIMEOUT_EN
    run_until_rsp("t4_rsp_seen", 30);
    check_eq("t4_latency", last_rsp_cyc - n0, TO);
    check_eq("t4_err", last_rsp_err, 1);
    check_eq("t4_data", last_rsp_data, 0);
    run_until_idle("t4_idle", 20);
    stuck = 1'b0;
`else
    n0 = n_rsp;
    repeat (40) step();
    check_eq("t4_no_rsp", n_rsp - n0, 0);
    check_eq("t4_still_busy", busy, 1);
    check_eq("t4_still_en", en_convert, 1);
    reset_dut("t4_rst");
    stuck = 1'b0;
`endif

    // Reset in the third RUN cycle
    req = 4'b0100; req_data[95:64] = $urandom();
    step();
    check_eq("t5_gnt0", gnt, 4'b0100);
    step();
    step();
    n0 = n_rsp;
    reset_dut("t5_rst");
    req = 4'b1010; req_data[63:32] = $urandom(); req_data[127:96] = $urandom();
    step();
    check_eq("t5_gnt_from_ptr0", gnt, 4'b0010);
    run_until_idle("t5_idle", 100);
    check_eq("t5_rsp_count", n_rsp - n0, 2);

    // Randomized traffic
    rand_en = 1'b1; keep_mode = 2;
    repeat (1500) step();
    rand_en = 1'b0; keep_mode = 0; extra_hold = 0;
    run_until_idle("rand_idle", 400);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
